gpu_framebuffer_dbuf: RTL and testbench
=======================================

Name: gpu_framebuffer_dbuf

Overview:
Parametrised double-buffered framebuffer, successor to the fixed 64x48x3 GPU framebuffer. Single clock domain: the pixel clock. Sits between the VGA timing generator and the VGA pins. A pre-synchronised CPU write port feeds it.
New over the previous generation: generic size and colour depth, vsync-aligned deferred buffer swap, hardware back-buffer clear, and pipeline-aligned sync outputs.

Parameters:
FB_WIDTH, 64, framebuffer columns
FB_HEIGHT, 48, framebuffer rows
COLOR_BITS, 3, bits per pixel
SCALE_SHIFT, 4, screen-to-framebuffer shift (x16 upscale)
VSYNC_ACTIVE, 0, active level of VSYNC_IN
ADDR_BITS (localparam), clog2(FB_WIDTH*FB_HEIGHT), write address width

Ports:
CLK  in  1  pixel clock
RESET  in  1  reset; synchronous, active-high
WR_EN  in  1  single-cycle pixel write strobe
WR_ADDR  in  ADDR_BITS  linear pixel index, y*FB_WIDTH+x
WR_DATA  in  COLOR_BITS  pixel value
SWAP_REQ  in  1  request front/back swap at next frame start
CLEAR_REQ  in  1  fill back buffer with CLEAR_COLOR
CLEAR_COLOR  in  COLOR_BITS  fill value, latched on accepted CLEAR_REQ
PIXEL_X  in  11  screen x from timing generator
PIXEL_Y  in  11  screen y from timing generator
ON_SCREEN  in  1  visible-area flag
HSYNC_IN  in  1  hsync from timing generator
VSYNC_IN  in  1  vsync from timing generator
PIXEL_OUT  out  COLOR_BITS  displayed pixel
HSYNC_OUT  out  1  HSYNC_IN delayed 2 cycles
VSYNC_OUT  out  1  VSYNC_IN delayed 2 cycles
FRONT_SEL  out  1  bank currently displayed
SWAP_PENDING  out  1  swap requested, not yet taken
BUSY  out  1  clear in progress

Behaviour:
- Reset values: PIXEL_OUT=0, FRONT_SEL=0, SWAP_PENDING=0, BUSY=0. HSYNC_OUT and VSYNC_OUT reset to the inactive level. FSM enters IDLE. RAM contents are not reset.
- Reset mid-clear aborts the clear; partially cleared contents remain.
- Two banks. The display reads bank FRONT_SEL. All writes go to bank ~FRONT_SEL.
- Display read pipeline:
  - Cycle 0: fb_x = PIXEL_X>>SCALE_SHIFT, fb_y = PIXEL_Y>>SCALE_SHIFT. Register address and an in-range flag (fb_x<FB_WIDTH && fb_y<FB_HEIGHT).
  - Cycle 1: RAM read.
  - Cycle 2: PIXEL_OUT valid.
  - Total latency 2 cycles. ON_SCREEN, HSYNC and VSYNC are delayed 2 cycles to match.
  - PIXEL_OUT=0 whenever delayed ON_SCREEN=0 or delayed in-range=0.
- CPU write, FSM in IDLE: WR_EN=1 with WR_ADDR<FB_WIDTH*FB_HEIGHT writes the back bank in the same cycle. Out-of-range addresses are ignored.
- Clear FSM, states IDLE and CLEARING:
  - IDLE: CLEAR_REQ=1 latches CLEAR_COLOR, zeroes the counter, goes to CLEARING.
  - CLEARING: one write per cycle to back[counter], counter increments, BUSY=1. After index FB_WIDTH*FB_HEIGHT-1 is written, return to IDLE.
  - A clear takes exactly FB_WIDTH*FB_HEIGHT cycles.
  - WR_EN and CLEAR_REQ are ignored while CLEARING.
- Swap:
  - SWAP_REQ=1 sets SWAP_PENDING from the next cycle. Repeat requests while pending have no effect.
  - Frame start is the cycle VSYNC_IN first equals VSYNC_ACTIVE (edge detected against a registered copy).
  - At frame start with SWAP_PENDING=1 and FSM in IDLE: FRONT_SEL toggles and SWAP_PENDING clears.
  - If CLEARING at frame start, the swap waits for the next frame start.
  - SWAP_REQ in the same cycle as frame start does not swap at that edge.
  - A write in the swap cycle goes to the bank that was back before the toggle.
- At most one swap per frame. FRONT_SEL never changes mid-frame.

Decomposition:
- Shared package gpu_pkg: clog2 function, FSM state encoding (ST_IDLE, ST_CLEARING), and the SCREEN_COORD_BITS=11 constant used by vga_timing.
- Sub-module fb_bank: one COLOR_BITS x FB_WIDTH*FB_HEIGHT RAM with one synchronous write port and one registered read port, inferable as iCE40 BRAM. It is instantiated twice; write enable is steered by FRONT_SEL.

Test Plan:
- Reset, then WR_EN addr 0 data 3'b101; SWAP_REQ; generate one vsync edge -> FRONT_SEL=1. When PIXEL_X=0, PIXEL_Y=0, ON_SCREEN=1, PIXEL_OUT=3'b101 exactly 2 cycles later.
- Write addr 64 (x0,y1) = 3'b010 -> PIXEL_OUT=010 for PIXEL_Y 16..31 and PIXEL_X 0..15 after swap. Same position with ON_SCREEN=0 -> 0.
- CLEAR_REQ with CLEAR_COLOR=3'b111 -> BUSY high for exactly 3072 cycles. A WR_EN issued mid-clear is lost. After swap, all 3072 pixels read 111.
- SWAP_REQ issued during clear, vsync edge while BUSY -> no toggle, SWAP_PENDING stays 1. Toggle occurs at the next vsync edge after BUSY falls.
- SWAP_REQ in the same cycle as the vsync edge -> no toggle that frame; toggle at the following edge. Two SWAP_REQs before one edge -> a single toggle.
- PIXEL_X=1024 (fb_x=64 is out of range) -> PIXEL_OUT=0. WR_ADDR=3072 -> no bank contents change. RESET asserted mid-clear -> BUSY=0 next cycle, FRONT_SEL=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: clear-FSM state encoding, screen coordinate width
// and a constant-foldable clog2 helper.
package gpu_pkg;

  localparam int SCREEN_COORD_BITS = 11;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } fb_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gpu_framebuffer_dbuf_if.sv
// Bus bundle between the CPU/timing-generator side (master) and the
// double-buffered framebuffer (slave).
interface gpu_framebuffer_dbuf_if #(
  parameter int FB_WIDTH   = 64,
  parameter int FB_HEIGHT  = 48,
  parameter int COLOR_BITS = 3
);
  import gpu_pkg::*;

  localparam int ADDR_BITS = clog2(FB_WIDTH * FB_HEIGHT);

  logic                         WR_EN;
  logic [ADDR_BITS-1:0]         WR_ADDR;
  logic [COLOR_BITS-1:0]        WR_DATA;
  logic                         SWAP_REQ;
  logic                         CLEAR_REQ;
  logic [COLOR_BITS-1:0]        CLEAR_COLOR;
  logic [SCREEN_COORD_BITS-1:0] PIXEL_X;
  logic [SCREEN_COORD_BITS-1:0] PIXEL_Y;
  logic                         ON_SCREEN;
  logic                         HSYNC_IN;
  logic                         VSYNC_IN;
  logic [COLOR_BITS-1:0]        PIXEL_OUT;
  logic                         HSYNC_OUT;
  logic                         VSYNC_OUT;
  logic                         FRONT_SEL;
  logic                         SWAP_PENDING;
  logic                         BUSY;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, SWAP_REQ, CLEAR_REQ, CLEAR_COLOR,
           PIXEL_X, PIXEL_Y, ON_SCREEN, HSYNC_IN, VSYNC_IN,
    input  PIXEL_OUT, HSYNC_OUT, VSYNC_OUT, FRONT_SEL, SWAP_PENDING, BUSY
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, SWAP_REQ, CLEAR_REQ, CLEAR_COLOR,
           PIXEL_X, PIXEL_Y, ON_SCREEN, HSYNC_IN, VSYNC_IN,
    output PIXEL_OUT, HSYNC_OUT, VSYNC_OUT, FRONT_SEL, SWAP_PENDING, BUSY
  );

endinterface

// File: rtl/fb_bank.sv
// One framebuffer bank: synchronous write port plus registered read port,
// shaped so it maps onto block RAM. Contents are intentionally not reset.
module fb_bank #(
  parameter int DEPTH     = 3072,
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_r [0:DEPTH-1];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/gpu_framebuffer_dbuf.sv
// Double-buffered framebuffer: two-cycle display read pipeline, CPU writes and
// hardware clear into the back bank, swap deferred to the next frame start.
module gpu_framebuffer_dbuf
  import gpu_pkg::*;
#(
  parameter int   FB_WIDTH     = 64,
  parameter int   FB_HEIGHT    = 48,
  parameter int   COLOR_BITS   = 3,
  parameter int   SCALE_SHIFT  = 4,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input logic                   CLK,
  input logic                   RESET,
  gpu_framebuffer_dbuf_if.slave bus
);

  localparam int                 FB_PIXELS   = FB_WIDTH * FB_HEIGHT;
  localparam int                 ADDR_BITS   = clog2(FB_PIXELS);
  localparam logic [ADDR_BITS:0] FB_PIXELS_W = FB_PIXELS[ADDR_BITS:0];
  localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(FB_PIXELS - 1);

  fb_state_t                    state_r, state_nxt_s;
  logic [ADDR_BITS-1:0]         clr_cnt_r, clr_cnt_nxt_s;
  logic [COLOR_BITS-1:0]        clr_color_r, clr_color_nxt_s;
  logic                         front_sel_r, swap_pending_r;
  logic                         frame_start_s, take_swap_s;

  logic [SCREEN_COORD_BITS-1:0] fb_x_s, fb_y_s;
  logic                         in_range_s;
  logic [ADDR_BITS-1:0]         lin_addr_s, rd_addr_r;
  logic                         in_range_d1_r, in_range_d2_r;
  logic                         on_d1_r, on_d2_r;
  logic                         hsync_d1_r, hsync_d2_r;
  logic                         vsync_d1_r, vsync_d2_r;
  logic                         bank_sel_d2_r;

  logic                         wr_en_s, we0_s, we1_s;
  logic [ADDR_BITS-1:0]         wr_addr_s;
  logic [COLOR_BITS-1:0]        wr_data_s;
  logic [COLOR_BITS-1:0]        rd_data0_s, rd_data1_s;

  // Screen-to-framebuffer coordinate mapping and range check.
  always_comb begin
    fb_x_s     = bus.PIXEL_X >> SCALE_SHIFT;
    fb_y_s     = bus.PIXEL_Y >> SCALE_SHIFT;
    in_range_s = (fb_x_s < SCREEN_COORD_BITS'(FB_WIDTH)) &&
                 (fb_y_s < SCREEN_COORD_BITS'(FB_HEIGHT));
    lin_addr_s = ADDR_BITS'(fb_y_s) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(fb_x_s);
  end

  // Display pipeline: address stage, then RAM stage with sideband kept in step.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_addr_r     <= {ADDR_BITS{1'b0}};
      in_range_d1_r <= 1'b0;
      in_range_d2_r <= 1'b0;
      on_d1_r       <= 1'b0;
      on_d2_r       <= 1'b0;
      hsync_d1_r    <= ~VSYNC_ACTIVE;
      hsync_d2_r    <= ~VSYNC_ACTIVE;
      vsync_d1_r    <= ~VSYNC_ACTIVE;
      vsync_d2_r    <= ~VSYNC_ACTIVE;
      bank_sel_d2_r <= 1'b0;
    end else begin
      rd_addr_r     <= in_range_s ? lin_addr_s : {ADDR_BITS{1'b0}};
      in_range_d1_r <= in_range_s;
      in_range_d2_r <= in_range_d1_r;
      on_d1_r       <= bus.ON_SCREEN;
      on_d2_r       <= on_d1_r;
      hsync_d1_r    <= bus.HSYNC_IN;
      hsync_d2_r    <= hsync_d1_r;
      vsync_d1_r    <= bus.VSYNC_IN;
      vsync_d2_r    <= vsync_d1_r;
      bank_sel_d2_r <= front_sel_r;
    end
  end

  // Write source: the clear engine owns the back bank while clearing.
  always_comb begin
    if (state_r == ST_CLEARING) begin
      wr_en_s   = ~RESET;
      wr_addr_s = clr_cnt_r;
      wr_data_s = clr_color_r;
    end else begin
      wr_en_s   = ~RESET && bus.WR_EN && ({1'b0, bus.WR_ADDR} < FB_PIXELS_W);
      wr_addr_s = bus.WR_ADDR;
      wr_data_s = bus.WR_DATA;
    end
    we0_s = wr_en_s && front_sel_r;
    we1_s = wr_en_s && !front_sel_r;
  end

  fb_bank #(.DEPTH(FB_PIXELS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(COLOR_BITS)) u_bank0 (
    .clk(CLK), .wr_en(we0_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .rd_addr(rd_addr_r), .rd_data(rd_data0_s)
  );

  fb_bank #(.DEPTH(FB_PIXELS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(COLOR_BITS)) u_bank1 (
    .clk(CLK), .wr_en(we1_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .rd_addr(rd_addr_r), .rd_data(rd_data1_s)
  );

  // Clear FSM next-state logic.
  always_comb begin
    state_nxt_s     = state_r;
    clr_cnt_nxt_s   = clr_cnt_r;
    clr_color_nxt_s = clr_color_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.CLEAR_REQ) begin
          state_nxt_s     = ST_CLEARING;
          clr_cnt_nxt_s   = {ADDR_BITS{1'b0}};
          clr_color_nxt_s = bus.CLEAR_COLOR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEARING: begin
        if (clr_cnt_r == LAST_IDX) begin
          state_nxt_s   = ST_IDLE;
          clr_cnt_nxt_s = {ADDR_BITS{1'b0}};
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + ADDR_BITS'(1);
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      clr_cnt_r   <= {ADDR_BITS{1'b0}};
      clr_color_r <= {COLOR_BITS{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      clr_cnt_r   <= clr_cnt_nxt_s;
      clr_color_r <= clr_color_nxt_s;
    end
  end

  // Frame start is the first cycle vsync reaches its active level; a request
  // arriving in that same cycle only sets pending, so it waits a frame.
  assign frame_start_s = (bus.VSYNC_IN == VSYNC_ACTIVE) && (vsync_d1_r != VSYNC_ACTIVE);
  assign take_swap_s   = frame_start_s && swap_pending_r && (state_r == ST_IDLE);

  // Bank swap bookkeeping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      front_sel_r    <= 1'b0;
      swap_pending_r <= 1'b0;
    end else if (take_swap_s) begin
      front_sel_r    <= ~front_sel_r;
      swap_pending_r <= 1'b0;
    end else if (bus.SWAP_REQ) begin
      swap_pending_r <= 1'b1;
    end
  end

  assign bus.PIXEL_OUT    = (on_d2_r && in_range_d2_r) ?
                            (bank_sel_d2_r ? rd_data1_s : rd_data0_s) : {COLOR_BITS{1'b0}};
  assign bus.HSYNC_OUT    = hsync_d2_r;
  assign bus.VSYNC_OUT    = vsync_d2_r;
  assign bus.FRONT_SEL    = front_sel_r;
  assign bus.SWAP_PENDING = swap_pending_r;
  assign bus.BUSY         = (state_r == ST_CLEARING);

endmodule

// File: tb/tb_gpu_framebuffer_dbuf.sv
// Scoreboard bench for gpu_framebuffer_dbuf: stimulus pushes timed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gpu_framebuffer_dbuf;

  localparam int SEL_PIX = 0, SEL_FRONT = 1, SEL_PEND = 2, SEL_BUSY = 3, SEL_HS = 4, SEL_VS = 5;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic [7:0] act;

  gpu_framebuffer_dbuf_if #(.FB_WIDTH(64), .FB_HEIGHT(48), .COLOR_BITS(3)) bus ();

  gpu_framebuffer_dbuf #(
    .FB_WIDTH(64), .FB_HEIGHT(48), .COLOR_BITS(3), .SCALE_SHIFT(4), .VSYNC_ACTIVE(1'b0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle.
  always @(negedge CLK) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        case (sb_q[i].sel)
          SEL_PIX:   act = 8'(bus.PIXEL_OUT);
          SEL_FRONT: act = 8'(bus.FRONT_SEL);
          SEL_PEND:  act = 8'(bus.SWAP_PENDING);
          SEL_BUSY:  act = 8'(bus.BUSY);
          SEL_HS:    act = 8'(bus.HSYNC_OUT);
          default:   act = 8'(bus.VSYNC_OUT);
        endcase
        checks++;
        if (sb_q[i].due != cyc) begin
          failures++;
          $display("FAIL %s overdue due=%0d cyc=%0d", sb_q[i].name, sb_q[i].due, cyc);
        end else if (act !== sb_q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", sb_q[i].name, cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_at(input int d, input int sel, input logic [7:0] v, input string n);
    exp_t e;
    e.due  = cyc + d;
    e.sel  = sel;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic write_px(input int a, input int d);
    bus.WR_ADDR = 12'(a);
    bus.WR_DATA = 3'(d);
    bus.WR_EN   = 1'b1;
    tick();
    bus.WR_EN   = 1'b0;
  endtask

  task automatic swap_req();
    bus.SWAP_REQ = 1'b1;
    expect_at(1, SEL_PEND, 8'd1, "pending_set");
    tick();
    bus.SWAP_REQ = 1'b0;
  endtask

  task automatic frame(input logic exp_front, input logic exp_pend, input logic req);
    bus.VSYNC_IN = 1'b0;
    bus.SWAP_REQ = req;
    expect_at(1, SEL_FRONT, 8'(exp_front), "front_sel");
    expect_at(1, SEL_PEND, 8'(exp_pend), "swap_pending");
    expect_at(1, SEL_VS, 8'd1, "vsync_delay_pre");
    expect_at(2, SEL_VS, 8'd0, "vsync_delay");
    tick();
    bus.VSYNC_IN = 1'b1;
    bus.SWAP_REQ = 1'b0;
    tick();
  endtask

  task automatic read_px(input int x, input int y, input logic on, input int e);
    bus.PIXEL_X   = 11'(x);
    bus.PIXEL_Y   = 11'(y);
    bus.ON_SCREEN = on;
    expect_at(2, SEL_PIX, 8'(e), "pixel");
    tick();
  endtask

  initial begin
    int k;
    RESET = 1'b1;
    bus.WR_EN = 1'b0; bus.WR_ADDR = 12'd0; bus.WR_DATA = 3'd0;
    bus.SWAP_REQ = 1'b0; bus.CLEAR_REQ = 1'b0; bus.CLEAR_COLOR = 3'd0;
    bus.PIXEL_X = 11'd0; bus.PIXEL_Y = 11'd0; bus.ON_SCREEN = 1'b1;
    bus.HSYNC_IN = 1'b0; bus.VSYNC_IN = 1'b0;
    repeat (3) tick();
    expect_at(1, SEL_PIX, 8'd0, "rst_pixel");
    expect_at(1, SEL_FRONT, 8'd0, "rst_front");
    expect_at(1, SEL_PEND, 8'd0, "rst_pending");
    expect_at(1, SEL_BUSY, 8'd0, "rst_busy");
    expect_at(1, SEL_HS, 8'd1, "rst_hsync");
    expect_at(1, SEL_VS, 8'd1, "rst_vsync");
    tick();
    bus.HSYNC_IN = 1'b1; bus.VSYNC_IN = 1'b1; bus.ON_SCREEN = 1'b0;
    RESET = 1'b0;
    repeat (2) tick();

    // First image: pixel 0 into bank1, swap it to the front.
    write_px(0, 5);
    swap_req();
    frame(1'b1, 1'b0, 1'b0);
    read_px(0, 0, 1'b1, 5);
    read_px(15, 15, 1'b1, 5);
    bus.HSYNC_IN = 1'b0;
    expect_at(1, SEL_HS, 8'd1, "hsync_delay_pre");
    expect_at(2, SEL_HS, 8'd0, "hsync_delay");
    tick();
    bus.HSYNC_IN = 1'b1;
    expect_at(2, SEL_HS, 8'd1, "hsync_release");
    tick();

    // Second image: (x0,y1) into bank0, swap back.
    write_px(64, 2);
    swap_req();
    frame(1'b0, 1'b0, 1'b0);
    read_px(0, 16, 1'b1, 2);
    read_px(15, 31, 1'b1, 2);
    read_px(0, 31, 1'b1, 2);
    read_px(15, 16, 1'b1, 2);
    read_px(0, 16, 1'b0, 0);
    read_px(1024, 0, 1'b1, 0);
    bus.ON_SCREEN = 1'b0;
    write_px(3072, 7);

    // Clear bank1 to 111; mid-clear write, swap and re-clear are all held off.
    k = cyc;
    bus.CLEAR_REQ = 1'b1; bus.CLEAR_COLOR = 3'd7;
    expect_at(1, SEL_BUSY, 8'd1, "busy_start");
    expect_at(3072, SEL_BUSY, 8'd1, "busy_last");
    expect_at(3073, SEL_BUSY, 8'd0, "busy_end");
    tick();
    bus.CLEAR_REQ = 1'b0;
    repeat (99) tick();
    write_px(0, 2);
    swap_req();
    repeat (98) tick();
    frame(1'b0, 1'b1, 1'b0);
    bus.CLEAR_REQ = 1'b1; bus.CLEAR_COLOR = 3'd0;
    tick();
    bus.CLEAR_REQ = 1'b0;
    while (cyc < k + 3075) tick();
    frame(1'b1, 1'b0, 1'b0);
    for (int y = 0; y < 48; y++) begin
      for (int x = 0; x < 64; x++) begin
        read_px(x * 16, y * 16, 1'b1, 7);
      end
    end
    bus.ON_SCREEN = 1'b0;

    // Request coinciding with frame start, then double request.
    frame(1'b1, 1'b1, 1'b1);
    frame(1'b0, 1'b0, 1'b0);
    swap_req();
    swap_req();
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a clear.
    bus.CLEAR_REQ = 1'b1; bus.CLEAR_COLOR = 3'd5;
    tick();
    bus.CLEAR_REQ = 1'b0;
    repeat (50) tick();
    RESET = 1'b1;
    expect_at(1, SEL_BUSY, 8'd0, "rst_mid_busy");
    expect_at(1, SEL_FRONT, 8'd0, "rst_mid_front");
    expect_at(1, SEL_PEND, 8'd0, "rst_mid_pending");
    tick();
    RESET = 1'b0;
    expect_at(1, SEL_BUSY, 8'd0, "post_rst_busy");
    tick();

    repeat (4) tick();
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
